// File: rtl/dvlsi_pkg.sv
// dvlsi_pkg: custom-0 opcode, accumulator funct3 codes and FSM states
package dvlsi_pkg;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] ACC_MAC = 3'b000;
  localparam logic [2:0] ACC_CLR = 3'b001;
  localparam logic [2:0] ACC_RD  = 3'b010;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/dvlsi_acc_mul.sv
// dvlsi_acc_mul: iterative shift-add multiplier, MUL_BITS multiplier bits per cycle, low XLEN product
module dvlsi_acc_mul #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_prod
);
  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);
  logic [XLEN-1:0] r_a, r_b, r_p;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] w_pp;
  assign w_pp = r_a * XLEN'(r_b[MUL_BITS-1:0]);
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_a   <= '0;
      r_b   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_p   <= '0;
      r_cnt <= CW'(STEPS);
    end else if (r_cnt != '0) begin
      r_p   <= r_p + w_pp;
      r_a   <= r_a << MUL_BITS;
      r_b   <= r_b >> MUL_BITS;
      r_cnt <= r_cnt - CW'(1);
    end
  end
  // done is raised during the last step so the final product is usable without an extra cycle
  assign o_done = r_cnt <= CW'(1);
  assign o_prod = (r_cnt == '0) ? r_p : r_p + w_pp;
endmodule

// File: rtl/dvlsi_mac_acc.sv
// dvlsi_mac_acc: CVXIF custom-0 MAC/CLR/RD coprocessor; define DVLSI_ACC_SATURATE_EN for signed saturating accumulate
module dvlsi_mac_acc
  import dvlsi_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ID_W     = 4,
  parameter int MUL_BITS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [XLEN-1:0] result_data_o,
  output logic            result_we_o
);
  state_e          r_state, w_next;
  logic [ID_W-1:0] r_id;
  logic [4:0]      r_rd;
  logic [2:0]      r_f3;
  logic            r_cmt;
  logic [XLEN-1:0] r_acc, r_data;
  logic            w_idle, w_dec_ok, w_take, w_cm, w_cmt, w_kill, w_done, w_fin, w_rv;
  logic            w_mul_done, w_unused;
  logic [ID_W-1:0] w_cid;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_prod, w_raw, w_sum, w_acc_next, w_rdata;
  assign w_unused = ^{issue_instr_i[31:15]};
  assign w_f3     = issue_instr_i[14:12];
  assign w_idle   = r_state == IDLE;
  assign w_dec_ok = issue_instr_i[6:0] == OPC_CUSTOM0 &&
                    (w_f3 == ACC_MAC || w_f3 == ACC_CLR || w_f3 == ACC_RD);
  assign w_take   = issue_valid_i && w_dec_ok && w_idle;
  // in IDLE the instruction being issued is the one a commit can refer to
  assign w_cid    = w_idle ? issue_id_i : r_id;
  assign w_cm     = commit_valid_i && commit_id_i == w_cid;
  assign w_cmt    = r_cmt || (w_cm && !commit_kill_i);
  assign w_kill   = w_cm && commit_kill_i && r_state != RESP;
  assign w_done   = r_f3 != ACC_MAC || w_mul_done;
  assign w_fin    = r_state == EXEC && w_next == RESP;
  dvlsi_acc_mul #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) u_mul (
    .clk    (clk_i),
    .rst    (rst_i),
    .i_start(w_take && w_f3 == ACC_MAC),
    .i_abort(w_kill),
    .i_a    (issue_rs1_i),
    .i_b    (issue_rs2_i),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );
  assign w_raw = r_acc + w_prod;
`ifdef DVLSI_ACC_SATURATE_EN
  logic w_ovf;
  assign w_ovf = r_acc[XLEN-1] == w_prod[XLEN-1] && w_raw[XLEN-1] != r_acc[XLEN-1];
  assign w_sum = !w_ovf ? w_raw :
                 r_acc[XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
`else
  assign w_sum = w_raw;
`endif
  assign w_acc_next = r_f3 == ACC_MAC ? w_sum : r_f3 == ACC_CLR ? '0 : r_acc;
  assign w_rdata    = r_f3 == ACC_MAC ? w_sum : r_acc;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (w_take && !w_kill) ? EXEC : IDLE;
      EXEC:    w_next = w_kill ? IDLE : (w_done && w_cmt) ? RESP : EXEC;
      RESP:    w_next = result_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_rv              = !rst_i && r_state == RESP;
    issue_ready_o     = !rst_i && w_idle;
    issue_accept_o    = !rst_i && w_take;
    issue_writeback_o = !rst_i && w_take;
    result_valid_o    = w_rv;
    result_we_o       = w_rv;
    result_id_o       = w_rv ? r_id : '0;
    result_rd_o       = w_rv ? r_rd : '0;
    result_data_o     = w_rv ? r_data : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id   <= '0;
      r_rd   <= '0;
      r_f3   <= '0;
      r_cmt  <= 1'b0;
      r_acc  <= '0;
      r_data <= '0;
    end else begin
      if (w_take) begin
        r_id  <= issue_id_i;
        r_rd  <= issue_instr_i[11:7];
        r_f3  <= w_f3;
        r_cmt <= w_cm && !commit_kill_i;
      end else begin
        r_cmt <= w_cmt;
      end
      if (w_fin) begin
        r_acc  <= w_acc_next;
        r_data <= w_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dvlsi_mac_acc.sv
// tb_dvlsi_mac_acc: directed self-checking bench for the MAC coprocessor
module tb_dvlsi_mac_acc;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [3:0]  issue_id_i = '0;
  logic [63:0] issue_rs1_i = '0;
  logic [63:0] issue_rs2_i = '0;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [63:0] result_data_o;
  logic        result_we_o;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dvlsi_mac_acc dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o)
  );
  localparam logic [6:0] OPC = 7'b0001011;
  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {17'd0, f3, rd, opc};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_issue(input logic [2:0] f3, input logic [3:0] id, input logic [4:0] rd,
                             input logic [63:0] a, input logic [63:0] b, input logic cmt);
    issue_valid_i = 1'b1; issue_instr_i = mk(f3, rd, OPC); issue_id_i = id;
    issue_rs1_i = a; issue_rs2_i = b;
    commit_valid_i = cmt; commit_id_i = id; commit_kill_i = 1'b0;
  endtask
  task automatic do_op(input logic [2:0] f3, input logic [3:0] id, input logic [63:0] a,
                       input logic [63:0] b, output int lat, output logic [63:0] data);
    drive_issue(f3, id, 5'd1, a, b, 1'b1);
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    lat = 1;
    while (!result_valid_o && lat < 100) begin
      tick();
      lat++;
    end
    data = result_data_o;
    if (!result_valid_o) lat = -1;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    drive_issue(3'b000, 4'd1, 5'd1, 64'd1, 64'd1, 1'b0);
    tick(); tick();
    n_vec++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", issue_ready_o); end
    n_vec++; if (issue_accept_o !== 1'b0) begin n_err++; $display("FAIL rst_accept got %b want 0", issue_accept_o); end
    n_vec++; if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", result_valid_o); end
    issue_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    n_vec++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got %b want 1", issue_ready_o); end
    n_vec++; if ({result_valid_o, result_we_o, result_data_o} !== 66'd0) begin n_err++; $display("FAIL post_rst_result got %h want 0", result_data_o); end
  endtask
  task automatic test_mac_basic();
    int lat; logic [63:0] d;
    do_op(3'b000, 4'd1, 64'd3, 64'd5, lat, d);
    n_vec++; if (lat !== 17) begin n_err++; $display("FAIL mac_lat got %0d want 17", lat); end
    n_vec++; if (d !== 64'd15) begin n_err++; $display("FAIL mac_data got %h want 15", d); end
    do_op(3'b010, 4'd2, 64'd0, 64'd0, lat, d);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rd_lat got %0d want 2", lat); end
    n_vec++; if (d !== 64'd15) begin n_err++; $display("FAIL rd_acc15 got %h want 15", d); end
  endtask
  task automatic test_wrap();
    int lat; logic [63:0] d;
    do_op(3'b000, 4'd3, 64'h1_0000_0000, 64'h1_0000_0000, lat, d);
    n_vec++; if (d !== 64'd15) begin n_err++; $display("FAIL wrap_mac got %h want 15", d); end
    do_op(3'b010, 4'd4, 64'd0, 64'd0, lat, d);
    n_vec++; if (d !== 64'd15) begin n_err++; $display("FAIL wrap_rd got %h want 15", d); end
    do_op(3'b001, 4'd5, 64'd0, 64'd0, lat, d);
    n_vec++; if (d !== 64'd15 || lat !== 2) begin n_err++; $display("FAIL clr_old got %h lat %0d want 15 lat 2", d, lat); end
    do_op(3'b010, 4'd6, 64'd0, 64'd0, lat, d);
    n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL clr_rd got %h want 0", d); end
  endtask
  task automatic test_kill();
    int lat; logic [63:0] d; int seen = 0;
    do_op(3'b000, 4'd7, 64'd7, 64'd1, lat, d);
    n_vec++; if (d !== 64'd7) begin n_err++; $display("FAIL kill_pre got %h want 7", d); end
    drive_issue(3'b000, 4'd3, 5'd2, 64'd2, 64'd2, 1'b0);
    tick();
    issue_valid_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      if (result_valid_o) seen++;
      tick();
    end
    commit_valid_i = 1'b1; commit_id_i = 4'd3; commit_kill_i = 1'b1;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    n_vec++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0 || seen != 0) begin n_err++; $display("FAIL kill_idle got ready %b valid %b seen %0d want 1 0 0", issue_ready_o, result_valid_o, seen); end
    do_op(3'b010, 4'd8, 64'd0, 64'd0, lat, d);
    n_vec++; if (d !== 64'd7) begin n_err++; $display("FAIL kill_acc got %h want 7", d); end
  endtask
  task automatic test_late_commit();
    int seen = 0;
    drive_issue(3'b000, 4'd5, 5'd9, 64'd6, 64'd7, 1'b0);
    tick();
    issue_valid_i = 1'b0;
    for (int i = 1; i < 27; i++) begin
      commit_valid_i = (i == 20 || i == 22); commit_id_i = (i == 20) ? 4'd6 : 4'd7;
      commit_kill_i = (i == 22);
      if (result_valid_o) seen++;
      tick();
    end
    n_vec++; if (seen != 0 || result_valid_o !== 1'b0 || issue_ready_o !== 1'b0) begin n_err++; $display("FAIL late_hold got seen %0d valid %b ready %b want 0 0 0", seen, result_valid_o, issue_ready_o); end
    commit_valid_i = 1'b1; commit_id_i = 4'd5; commit_kill_i = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    n_vec++; if (result_valid_o !== 1'b1 || result_data_o !== 64'd49) begin n_err++; $display("FAIL late_result got valid %b data %h want 1 49", result_valid_o, result_data_o); end
    n_vec++; if (result_id_o !== 4'd5 || result_rd_o !== 5'd9 || result_we_o !== 1'b1) begin n_err++; $display("FAIL late_meta got id %h rd %0d we %b want 5 9 1", result_id_o, result_rd_o, result_we_o); end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask
  task automatic test_reject();
    issue_valid_i = 1'b1; issue_instr_i = mk(3'b111, 5'd3, OPC); issue_id_i = 4'd1;
    #1;
    n_vec++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0 || issue_ready_o !== 1'b1) begin n_err++; $display("FAIL rej_f3 got acc %b wb %b rdy %b want 0 0 1", issue_accept_o, issue_writeback_o, issue_ready_o); end
    tick();
    issue_instr_i = mk(3'b000, 5'd3, 7'b0110011);
    #1;
    n_vec++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0 || issue_ready_o !== 1'b1) begin n_err++; $display("FAIL rej_opc got acc %b wb %b rdy %b want 0 0 1", issue_accept_o, issue_writeback_o, issue_ready_o); end
    tick();
    issue_valid_i = 1'b0;
    n_vec++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin n_err++; $display("FAIL rej_idle got rdy %b valid %b want 1 0", issue_ready_o, result_valid_o); end
  endtask
  task automatic test_back_to_back();
    logic [63:0] d0; int bad = 0;
    drive_issue(3'b010, 4'd9, 5'd17, 64'd0, 64'd0, 1'b1);
    #1;
    n_vec++; if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b1) begin n_err++; $display("FAIL acc_rd got acc %b wb %b want 1 1", issue_accept_o, issue_writeback_o); end
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    tick();
    d0 = result_data_o;
    for (int i = 0; i < 4; i++) begin
      if (!result_valid_o || result_data_o !== d0 || result_rd_o !== 5'd17 || result_id_o !== 4'd9) bad++;
      tick();
    end
    n_vec++; if (bad != 0 || d0 !== 64'd49) begin n_err++; $display("FAIL hold_resp got data %h bad %0d want 49 0", d0, bad); end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    n_vec++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready got rdy %b valid %b want 1 0", issue_ready_o, result_valid_o); end
  endtask
  task automatic test_overflow();
    int lat; logic [63:0] d; logic [63:0] exp_v;
`ifdef DVLSI_ACC_SATURATE_EN
    exp_v = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp_v = 64'h8000_0000_0000_0010;
`endif
    do_op(3'b001, 4'd1, 64'd0, 64'd0, lat, d);
    do_op(3'b000, 4'd2, 64'h7FFF_FFFF_FFFF_FFF0, 64'd1, lat, d);
    n_vec++; if (d !== 64'h7FFF_FFFF_FFFF_FFF0) begin n_err++; $display("FAIL ovf_pre got %h want 7ffffffffffffff0", d); end
    do_op(3'b000, 4'd3, 64'd4, 64'd8, lat, d);
    n_vec++; if (d !== exp_v) begin n_err++; $display("FAIL ovf_sum got %h want %h", d, exp_v); end
  endtask
  task automatic test_midreset();
    int lat; logic [63:0] d;
    drive_issue(3'b000, 4'd4, 5'd1, 64'd9, 64'd9, 1'b1);
    tick();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    n_vec++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst got rdy %b valid %b want 1 0", issue_ready_o, result_valid_o); end
    do_op(3'b010, 4'd5, 64'd0, 64'd0, lat, d);
    n_vec++; if (d !== 64'd0) begin n_err++; $display("FAIL midrst_acc got %h want 0", d); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_mac_basic();
    test_wrap();
    test_kill();
    test_late_commit();
    test_reject();
    test_back_to_back();
    test_overflow();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
